// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage core: M/W forwarding, load-use stalls,
// E-stage redirects and multi-cycle MDU stalls (fixed-latency or done-handshake).
module hazard_unit_mc #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 0,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic              resultsrc_e,
  input  logic              pcsrc_e,
  input  logic              mdu_start_e,
  input  logic              mdu_done_i,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              mdu_busy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int LAT_W = (MDU_LAT < 1) ? 1 : $clog2(MDU_LAT + 1);
  localparam bit FIXED = (MDU_LAT != 0);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [LAT_W-1:0]   r_latCnt;
  logic [LAT_W-1:0]   w_latCntNext;
  logic [CNT_W-1:0]   r_stallCnt;
  logic               w_done;
  logic               w_mduStall;
  logic               w_loadUse;

  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rdM,
    input logic              wrM,
    input logic [REG_AW-1:0] rdW,
    input logic              wrW
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0 && wrM && rs == rdM)
      sel = 2'b10;
    else if (rs != '0 && wrW && rs == rdW)
      sel = 2'b01;
    return sel;
  endfunction

  assign w_loadUse = resultsrc_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // A redirect in the same cycle as an MDU start kills the op, so the FSM stays idle.
  always_comb begin
    w_nextState  = r_state;
    w_latCntNext = r_latCnt;
    w_mduStall   = 1'b0;
    w_done       = FIXED ? (r_latCnt == LAT_W'(1)) : mdu_done_i;
    case (r_state)
      IDLE: begin
        if (mdu_start_e && !pcsrc_e) begin
          w_mduStall  = 1'b1;
          w_nextState = BUSY;
          if (FIXED) w_latCntNext = LAT_W'(MDU_LAT);
        end
      end
      BUSY: begin
        if (w_done) begin
          w_nextState = IDLE;
        end else begin
          w_mduStall = 1'b1;
          if (FIXED) w_latCntNext = r_latCnt - LAT_W'(1);
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    forward_a_e = 2'b00;
    forward_b_e = 2'b00;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    mdu_busy_o  = 1'b0;
    if (rst_n) begin
      forward_a_e = fwdSel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
      forward_b_e = fwdSel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
      mdu_busy_o  = (r_state == BUSY);
      if (pcsrc_e) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (w_mduStall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        flush_m = 1'b1;
      end else if (w_loadUse) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_latCnt   <= '0;
      r_stallCnt <= '0;
    end else begin
      r_state  <= w_nextState;
      r_latCnt <= w_latCntNext;
      if (stall_f && (r_stallCnt != '1))
        r_stallCnt <= r_stallCnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stallCnt;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: a fixed-latency (MDU_LAT=3) and a
// handshake-mode (MDU_LAT=0) instance share stimulus; expectations are queued per cycle.
module tb_hazard_unit_mc;

  typedef struct {
    logic       rstn;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwm, regww, ressrc, pcsrc, start, done;
  } stim_t;

  typedef struct {
    string       name;
    int          sel;
    logic [10:0] outs;
    logic [31:0] cnt;
  } exp_t;

  // Output vector layout: {fwdA, fwdB, stallF, stallD, stallE, flushD, flushE, flushM, busy}
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] LDUSE = 7'b1100100;
  localparam logic [6:0] REDIR = 7'b0001100;
  localparam logic [6:0] MENTR = 7'b1110010;
  localparam logic [6:0] MHOLD = 7'b1110011;
  localparam logic [6:0] MDONE = 7'b0000001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwrite_m, regwrite_w, resultsrc_e, pcsrc_e, mdu_start_e, mdu_done_i;

  logic [1:0]  faF, fbF, faH, fbH;
  logic        sfF, sdF, seF, fdF, feF, fmF, busyF;
  logic        sfH, sdH, seH, fdH, feH, fmH, busyH;
  logic [31:0] cntF, cntH;
  logic [10:0] outsF, outsH;

  int   nChecks = 0;
  int   nFails  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MDU_LAT(3), .CNT_W(32)) dutFix (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .resultsrc_e(resultsrc_e), .pcsrc_e(pcsrc_e),
    .mdu_start_e(mdu_start_e), .mdu_done_i(mdu_done_i),
    .forward_a_e(faF), .forward_b_e(fbF),
    .stall_f(sfF), .stall_d(sdF), .stall_e(seF),
    .flush_d(fdF), .flush_e(feF), .flush_m(fmF),
    .mdu_busy_o(busyF), .stall_cnt_o(cntF)
  );

  hazard_unit_mc #(.REG_AW(5), .MDU_LAT(0), .CNT_W(32)) dutHs (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .resultsrc_e(resultsrc_e), .pcsrc_e(pcsrc_e),
    .mdu_start_e(mdu_start_e), .mdu_done_i(mdu_done_i),
    .forward_a_e(faH), .forward_b_e(fbH),
    .stall_f(sfH), .stall_d(sdH), .stall_e(seH),
    .flush_d(fdH), .flush_e(feH), .flush_m(fmH),
    .mdu_busy_o(busyH), .stall_cnt_o(cntH)
  );

  assign outsF = {faF, fbF, sfF, sdF, seF, fdF, feF, fmF, busyF};
  assign outsH = {faH, fbH, sfH, sdH, seH, fdH, feH, fmH, busyH};

  // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
  task automatic applyStimulus(input stim_t st, input int sel, input logic [3:0] fwd,
                               input logic [6:0] ctl, input logic [31:0] cnt, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n       = st.rstn;
    rs1_d       = st.rs1d;  rs2_d = st.rs2d;
    rs1_e       = st.rs1e;  rs2_e = st.rs2e;
    rd_e        = st.rde;   rd_m  = st.rdm;  rd_w = st.rdw;
    regwrite_m  = st.regwm; regwrite_w = st.regww;
    resultsrc_e = st.ressrc;
    pcsrc_e     = st.pcsrc;
    mdu_start_e = st.start;
    mdu_done_i  = st.done;
    e.name = nm;
    e.sel  = sel;
    e.outs = {fwd, ctl};
    e.cnt  = cnt;
    q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [10:0] o;
    logic [31:0] c;
    o = (e.sel == 1) ? outsH : outsF;
    c = (e.sel == 1) ? cntH : cntF;
    nChecks++;
    if (o !== e.outs) begin
      nFails++;
      $display("[TB] FAIL %s outputs: got %b, expected %b", e.name, o, e.outs);
    end
    nChecks++;
    if (c !== e.cnt) begin
      nFails++;
      $display("[TB] FAIL %s stall_cnt: got %0d, expected %0d", e.name, c, e.cnt);
    end
  endtask

  // Monitor: one queued expectation per cycle, compared on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) checkOutput(q.pop_front());
  end

  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {regwrite_m, regwrite_w, resultsrc_e, pcsrc_e, mdu_start_e, mdu_done_i} = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    s = '{default: '0};
    rst_n = 1'b0;
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {regwrite_m, regwrite_w, resultsrc_e, pcsrc_e, mdu_start_e, mdu_done_i} = '0;

    // Reset state: even with a forwarding match and load-use, everything stays 0.
    s.rs1e = 5; s.rdm = 5; s.regwm = 1; s.ressrc = 1; s.rde = 3; s.rs2d = 3;
    applyStimulus(s, 0, 4'b0000, NONE, 0, "reset_state");
    doReset();

    // Forwarding
    s = '{default: '0}; s.rstn = 1;
    s.rs1e = 5; s.rdm = 5; s.regwm = 1; s.rdw = 5; s.regww = 1;
    applyStimulus(s, 0, 4'b1000, NONE, 0, "fwd_a_m_over_w");
    s.rs1e = 0;
    applyStimulus(s, 0, 4'b0000, NONE, 0, "fwd_a_r0");
    s.rs2e = 7; s.rdw = 7;
    applyStimulus(s, 0, 4'b0001, NONE, 0, "fwd_b_w");
    s.rdm = 7;
    applyStimulus(s, 1, 4'b0010, NONE, 0, "fwd_b_m_wins");
    s.regwm = 0;
    applyStimulus(s, 0, 4'b0001, NONE, 0, "fwd_b_m_nowrite");
    s.regww = 0;
    applyStimulus(s, 0, 4'b0000, NONE, 0, "fwd_b_no_write");

    // Load-use
    s = '{default: '0}; s.rstn = 1;
    s.ressrc = 1; s.rde = 3; s.rs2d = 3;
    applyStimulus(s, 0, 4'b0000, LDUSE, 0, "loaduse_rs2");
    s.rde = 0; s.rs2d = 0;
    applyStimulus(s, 0, 4'b0000, NONE, 1, "loaduse_rd0");
    s.rde = 4; s.rs1d = 4;
    applyStimulus(s, 0, 4'b0000, LDUSE, 1, "loaduse_rs1");
    s.ressrc = 0;
    applyStimulus(s, 0, 4'b0000, NONE, 2, "loaduse_not_load");

    // Redirect beats load-use
    s = '{default: '0}; s.rstn = 1;
    s.ressrc = 1; s.rde = 3; s.rs2d = 3; s.pcsrc = 1;
    applyStimulus(s, 0, 4'b0000, REDIR, 2, "redirect_over_loaduse");
    s = '{default: '0}; s.rstn = 1;
    applyStimulus(s, 0, 4'b0000, NONE, 2, "redirect_cnt_hold");

    // Redirect together with an MDU start keeps the FSM idle
    s.start = 1; s.pcsrc = 1;
    applyStimulus(s, 0, 4'b0000, REDIR, 2, "redirect_over_mdu");
    s.start = 0; s.pcsrc = 0;
    applyStimulus(s, 0, 4'b0000, NONE, 2, "redirect_mdu_idle");

    // Fixed-latency MDU (MDU_LAT=3)
    doReset();
    s = '{default: '0}; s.rstn = 1; s.start = 1;
    applyStimulus(s, 0, 4'b0000, MENTR, 0, "fix_entry");
    applyStimulus(s, 0, 4'b0000, MHOLD, 1, "fix_busy1");
    applyStimulus(s, 0, 4'b0000, MHOLD, 2, "fix_busy2");
    applyStimulus(s, 0, 4'b0000, MDONE, 3, "fix_done");
    s.start = 0;
    applyStimulus(s, 0, 4'b0000, NONE, 3, "fix_idle");

    // Handshake MDU: a done pulse while idle is ignored
    doReset();
    s = '{default: '0}; s.rstn = 1; s.done = 1;
    applyStimulus(s, 1, 4'b0000, NONE, 0, "hs_done_in_idle");
    s.done = 0; s.start = 1;
    applyStimulus(s, 1, 4'b0000, MENTR, 0, "hs_entry");
    for (int i = 1; i <= 4; i++)
      applyStimulus(s, 1, 4'b0000, MHOLD, 32'(i), $sformatf("hs_wait%0d", i));
    s.done = 1;
    applyStimulus(s, 1, 4'b0000, MDONE, 5, "hs_done");
    s.done = 0; s.start = 0;
    applyStimulus(s, 1, 4'b0000, NONE, 5, "hs_idle");

    // Reset while BUSY
    doReset();
    s = '{default: '0}; s.rstn = 1; s.start = 1;
    applyStimulus(s, 0, 4'b0000, MENTR, 0, "rst_entry");
    applyStimulus(s, 0, 4'b0000, MHOLD, 1, "rst_busy");
    s.rstn = 0; s.rs1e = 5; s.rdm = 5; s.regwm = 1;
    applyStimulus(s, 0, 4'b0000, NONE, 0, "rst_mid_op");
    s.rstn = 1; s.start = 0;
    applyStimulus(s, 0, 4'b1000, NONE, 0, "rst_release");
    applyStimulus(s, 0, 4'b1000, NONE, 0, "rst_stays_idle");

    begin
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      if (q.size() > 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL drain: %0d expectations left, expected 0", q.size());
      end
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
